// File: rtl/seq_addsub_unit.sv
// Multi-cycle two's-complement add/subtract: one CHUNK-bit slice per clock, carry kept in a flop.
// Optional build macro SEQ_ADDSUB_SATURATE_EN clamps overflowing results instead of wrapping.
module seq_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
`ifdef SEQ_ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic              op_q, op_d, carry_q, carry_d;
    logic              flag_c_q, flag_c_d, flag_v_q, flag_v_d;
    logic              flag_n_q, flag_n_d, flag_z_q, flag_z_d;

    logic [CHUNK-1:0]  a_slice_s, b_slice_s;
    logic [CHUNK:0]    sum_s;
    logic              ovf_s;
    logic [WIDTH-1:0]  merged_s, final_s;

    // Slice datapath: one CHUNK-wide add with the stored carry, merged into the partial result.
    always_comb begin
        a_slice_s = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_slice_s = op_q ? ~b_q[int'(idx_q)*CHUNK +: CHUNK] : b_q[int'(idx_q)*CHUNK +: CHUNK];
        sum_s     = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the slice MSB is recovered from the MSB sum bit; only meaningful on the last slice.
        ovf_s     = (a_slice_s[CHUNK-1] ^ b_slice_s[CHUNK-1] ^ sum_s[CHUNK-1]) ^ sum_s[CHUNK];
        merged_s  = result_q;
        merged_s[int'(idx_q)*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
        final_s   = merged_s;
`ifdef SEQ_ADDSUB_SATURATE_EN
        // On overflow the true result has the sign of operand A.
        if (ovf_s) begin
            final_s = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            final_s = merged_s;
        end
`endif
    end

    // Next-state and register-input logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_sub;
                    idx_d   = '0;
                    carry_d = op_sub;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d = sum_s[CHUNK];
                if (idx_q == LAST_IDX) begin
                    result_d = final_s;
                    flag_c_d = op_q ? ~sum_s[CHUNK] : sum_s[CHUNK];
                    flag_v_d = ovf_s;
                    flag_n_d = final_s[WIDTH-1];
                    flag_z_d = (final_s == '0);
                    idx_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    result_d = merged_s;
                    idx_d    = idx_q + 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed self-checking bench for seq_addsub_unit (WIDTH=32, CHUNK=8).
module tb_seq_addsub_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sub = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_c, flag_v, flag_n, flag_z;

    int n_cmp = 0;
    int n_bad = 0;

    seq_addsub_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    // Issue one op; lat = cycle in which out_valid is first seen, counting the accept edge as the start of cycle 1.
    // Returns with out_valid high (unless timed out) and out_ready still low.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sub, output int lat);
        int wait_c;
        wait_c = 0;
        @(negedge clk);
        while (!in_ready && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        a = av; b = bv; op_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'hCAFEF00D; op_sub = ~sub;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
            {flag_c, flag_v, flag_n, flag_z} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset: rdy=%b vld=%b res=%h cvnz=%b%b%b%b, required rdy=1 vld=0 res=0 cvnz=0000",
                     in_ready, out_valid, result, flag_c, flag_v, flag_n, flag_z);
        end
    endtask

    // Runs one op and checks result, flags {c,v,n,z} and latency.
    task automatic test_vector(input string name, input logic [31:0] av, input logic [31:0] bv,
                               input logic sub, input logic [31:0] exp_res, input logic [3:0] exp_cvnz);
        int lat;
        issue(av, bv, sub, lat);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL %s latency: got cycle %0d, required 5", name, lat);
        end
        n_cmp++;
        if (result !== exp_res) begin
            n_bad++;
            $display("FAIL %s result: got %h, required %h", name, result, exp_res);
        end
        n_cmp++;
        if ({flag_c, flag_v, flag_n, flag_z} !== exp_cvnz) begin
            n_bad++;
            $display("FAIL %s flags cvnz: got %b%b%b%b, required %b", name, flag_c, flag_v, flag_n, flag_z, exp_cvnz);
        end
        release_result();
    endtask

    task automatic test_arith();
        test_vector("sub_5_3",     32'd5,          32'd3,          1'b1, 32'd2,          4'b0000);
        test_vector("sub_borrow",  32'd3,          32'd5,          1'b1, 32'hFFFFFFFE,   4'b1010);
`ifdef SEQ_ADDSUB_SATURATE_EN
        test_vector("add_ovf",     32'h7FFFFFFF,   32'd1,          1'b0, 32'h7FFFFFFF,   4'b0100);
        test_vector("sub_ovf",     32'h80000000,   32'd1,          1'b1, 32'h80000000,   4'b0110);
`else
        test_vector("add_ovf",     32'h7FFFFFFF,   32'd1,          1'b0, 32'h80000000,   4'b0110);
        test_vector("sub_ovf",     32'h80000000,   32'd1,          1'b1, 32'h7FFFFFFF,   4'b0100);
`endif
        test_vector("cross_chunk", 32'h00FFFFFF,   32'd1,          1'b0, 32'h01000000,   4'b0000);
        test_vector("sub_zero",    32'h00001234,   32'h00001234,   1'b1, 32'd0,          4'b0001);
        test_vector("add_carry",   32'hFFFFFFFF,   32'd1,          1'b0, 32'd0,          4'b1001);
    endtask

    task automatic test_handshake();
        int lat;
        issue(32'd10, 32'd20, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 32'h11111111 * i;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd30) begin
                n_bad++;
                $display("FAIL stall cyc%0d: vld=%b rdy=%b res=%h, required vld=1 rdy=0 res=0000001e",
                         i, out_valid, in_ready, result);
            end
        end
        in_valid = 1'b0;
        release_result();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_drop: rdy=%b vld=%b, required rdy=1 vld=0 (no queued op)", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        a = 32'h01020304; b = 32'h00000001; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
            {flag_c, flag_v, flag_n, flag_z} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_run_reset: rdy=%b vld=%b res=%h cvnz=%b%b%b%b, required rdy=1 vld=0 res=0 cvnz=0000",
                     in_ready, out_valid, result, flag_c, flag_v, flag_n, flag_z);
        end
        test_vector("after_reset", 32'd100, 32'd1, 1'b1, 32'd99, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_handshake();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
